// File: rtl/frame_loader_pkg.sv
// Shared types and default sizing for the frame loader.
//   NUM_PIXELS / ADDR_W / SYNC_STAGES : default geometry (16x16x16 cube)
//   pixel_t                           : one 24-bit {R,G,B} frame-memory word
//   rx_state_t                        : receive FSM states
package frame_loader_pkg;

    localparam int unsigned NUM_PIXELS  = 4096;
    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned SYNC_STAGES = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        DONE,
        DROP
    } rx_state_t;

endpackage

// File: rtl/frame_loader_if.sv
// Host/controller-facing signal bundle of the frame loader.
//   spi_sclk/spi_mosi/spi_cs_n : host serial link (SPI mode 0, MSB first)
//   frame_sync                 : controller display-frame boundary pulse
//   rd_addr/rd_data            : controller read port on the front buffer
//   swap_pending/overrun_err/frame_err : loader status
// master = host/controller side, slave = frame_loader.
interface frame_loader_if #(
    parameter int unsigned ADDR_W = frame_loader_pkg::ADDR_W
);
    logic                     spi_sclk;
    logic                     spi_mosi;
    logic                     spi_cs_n;
    logic                     frame_sync;
    logic [ADDR_W-1:0]        rd_addr;
    frame_loader_pkg::pixel_t rd_data;
    logic                     swap_pending;
    logic                     overrun_err;
    logic                     frame_err;

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n, frame_sync, rd_addr,
        input  rd_data, swap_pending, overrun_err, frame_err
    );

    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n, frame_sync, rd_addr,
        output rd_data, swap_pending, overrun_err, frame_err
    );
endinterface

// File: rtl/frame_loader_spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the async host pins into clk,
// detects sclk rising edges and shifts MOSI in MSB first.
//   clk, reset_n   : system clock, async active-low reset
//   i_sclk/i_mosi/i_cs_n : raw host pins
//   o_cs_n         : synchronised chip select
//   o_byte_valid   : 1-cycle pulse, o_byte holds the completed byte
module frame_loader_spi_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_cs_n,
    output logic       o_cs_n,
    output logic       o_byte_valid,
    output logic [7:0] o_byte
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic                   r_byte_valid;
    logic [7:0]             r_byte;

    logic w_sclk;
    logic w_mosi;
    logic w_cs_n;
    logic w_rise;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_d;

    // cs_n chain resets low so a select held low through reset never looks
    // like a fresh idle-to-active transition to the frame FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_sclk_d    <= w_sclk;
        end
    end

    // Bit shifter; a deselected link discards any partial byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte       <= {r_shift, w_mosi};
                end
            end
        end
    end

    assign o_cs_n       = w_cs_n;
    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;

endmodule

// File: rtl/frame_loader.sv
// Frame loader: assembles host SPI bytes into 24-bit pixels, writes them into
// the back half of a double-buffered frame memory and swaps buffers only on
// the controller's frame_sync, so a displayed frame is never torn.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : SPI pins, frame_sync, rd_addr in; rd_data and status out
// Optional build macro FRAME_LOADER_CHECKSUM_EN: the payload is followed by a
// modulo-256 sum byte and a frame is accepted only if it matches.
module frame_loader #(
    parameter int unsigned NUM_PIXELS  = frame_loader_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W      = frame_loader_pkg::ADDR_W,
    parameter int unsigned SYNC_STAGES = frame_loader_pkg::SYNC_STAGES
) (
    input  logic          clk,
    input  logic          reset_n,
    frame_loader_if.slave bus
);
    import frame_loader_pkg::*;

    localparam int unsigned MEM_DEPTH = 2 * NUM_PIXELS;
    localparam int unsigned LAST_PIX  = NUM_PIXELS - 1;

    logic       w_cs_n;
    logic       w_byte_valid;
    logic [7:0] w_byte;

    rx_state_t         r_state;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic              r_armed;
    logic              r_rejected;
    logic              r_front_sel;
    logic              r_swap_pending;
    logic              r_overrun_err;
    logic              r_frame_err;
    logic              r_wr_en;
    logic [ADDR_W:0]   r_wr_addr;
    pixel_t            r_wr_data;
    pixel_t            r_rd_data;
    pixel_t            r_mem [MEM_DEPTH];
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    frame_loader_spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_sclk       (bus.spi_sclk),
        .i_mosi       (bus.spi_mosi),
        .i_cs_n       (bus.spi_cs_n),
        .o_cs_n       (w_cs_n),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte)
    );

    // Receive FSM, buffer swap and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_pix_addr     <= '0;
            r_byte_idx     <= '0;
            r_red          <= '0;
            r_green        <= '0;
            r_armed        <= 1'b0;
            r_rejected     <= 1'b0;
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_overrun_err  <= 1'b0;
            r_frame_err    <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            r_csum         <= '0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_wr_en     <= 1'b0;

            // A frame may only start after cs_n has been seen deselected.
            if (w_cs_n) begin
                r_armed <= 1'b1;
            end

            // Swap uses the registered pending flag, so a completion landing
            // on the same edge as frame_sync waits for the next frame_sync.
            if (bus.frame_sync && r_swap_pending) begin
                r_front_sel    <= ~r_front_sel;
                r_swap_pending <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_armed && !w_cs_n) begin
                        if (r_swap_pending) begin
                            r_state       <= DROP;
                            r_overrun_err <= 1'b1;
                        end else begin
                            r_state    <= RECV;
                            r_pix_addr <= '0;
                            r_byte_idx <= '0;
                            r_rejected <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                        end
                    end
                end

                RECV: begin
                    if (w_cs_n) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                        r_pix_addr  <= '0;
                        r_byte_idx  <= '0;
                    end else if (w_byte_valid) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                        r_csum <= r_csum + w_byte;
`endif
                        case (r_byte_idx)
                            2'd0: begin
                                r_red      <= w_byte;
                                r_byte_idx <= 2'd1;
                            end
                            2'd1: begin
                                r_green    <= w_byte;
                                r_byte_idx <= 2'd2;
                            end
                            default: begin
                                r_byte_idx <= 2'd0;
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= {~r_front_sel, r_pix_addr};
                                r_wr_data  <= '{r: r_red, g: r_green, b: w_byte};
                                r_pix_addr <= r_pix_addr + ADDR_W'(1);
                                if (r_pix_addr == ADDR_W'(LAST_PIX)) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                                    r_state <= CHECK;
`else
                                    r_state <= DONE;
`endif
                                end
                            end
                        endcase
                    end
                end

`ifdef FRAME_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_cs_n) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_state <= DONE;
                        if (w_byte != r_csum) begin
                            r_frame_err <= 1'b1;
                            r_rejected  <= 1'b1;
                        end
                    end
                end
`endif

                DONE: begin
                    if (w_cs_n) begin
                        r_state <= IDLE;
                        if (!r_rejected) begin
                            r_swap_pending <= 1'b1;
                        end
                    end else if (w_byte_valid && !r_rejected) begin
                        // Trailing bytes: reject once, keep waiting for cs_n.
                        r_frame_err <= 1'b1;
                        r_rejected  <= 1'b1;
                    end
                end

                DROP: begin
                    if (w_cs_n) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Frame memory write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    // Registered front-buffer read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{r_front_sel, bus.rd_addr}];
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.swap_pending = r_swap_pending;
    assign bus.overrun_err  = r_overrun_err;
    assign bus.frame_err    = r_frame_err;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader with a 4-pixel frame: scripted frame table, hand
// sequences for same-edge swap and mid-frame reset, then random frames
// checked against a frame-level model of accept/reject/swap behaviour.
module tb_frame_loader;

    localparam int unsigned NPIX = 4;
    localparam int unsigned AW   = 2;
    localparam int          PAY  = 12;
`ifdef FRAME_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    frame_loader_if #(.ADDR_W(AW)) bus();

    frame_loader #(
        .NUM_PIXELS  (NPIX),
        .ADDR_W      (AW),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          npay;
        logic [7:0]  base;
        int          extra;
        bit          do_sync;
        int          exp_err;
        bit          exp_pend_pre;
        bit          exp_pend_post;
        bit          exp_ovr;
        logic [23:0] exp_px0;
        logic [23:0] exp_px3;
    } vec_t;

    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_cnt  = 0;
    int          e0;
    logic [7:0]  tx_q[$];
    logic [23:0] m_front[NPIX];
    logic [23:0] m_back[NPIX];
    bit          m_pending;
    bit          m_overrun;
    bit          exp_err;
    bit          seen;
    logic [23:0] d;
    logic [AW-1:0] a;
    int          kind;
    logic [7:0]  base;

    // Frame-error pulses, counted so a pulse between samples is not missed.
    always @(negedge clk) begin
        if (reset_n && bus.frame_err) err_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic build(input int npay, input logic [7:0] b0, input int extra, input bit corrupt);
        logic [7:0] s;
        logic [7:0] v;
        s = 8'h00;
        tx_q.delete();
        for (int i = 0; i < npay; i++) begin
            v = 8'(b0 + 8'(i));
            tx_q.push_back(v);
            s = 8'(s + v);
        end
        if (CS_EN && npay == PAY) tx_q.push_back(corrupt ? 8'(s + 8'd1) : s);
        for (int i = 0; i < extra; i++) tx_q.push_back(8'hEE);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.spi_mosi = b[i];
            repeat (4) @(negedge clk);
            bus.spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame();
        bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        repeat (6) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        bus.frame_sync = 1'b1;
        @(negedge clk);
        bus.frame_sync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_px(input logic [AW-1:0] ad, output logic [23:0] dat);
        @(negedge clk);
        bus.rd_addr = ad;
        @(negedge clk);
        dat = bus.rd_data;
    endtask

    // Frame-level rule: accepted only if the back buffer is free and the
    // byte count (and checksum, when enabled) is exactly right.
    task automatic model_frame(output bit e);
        logic [7:0] s;
        bit ok;
        e = 1'b0;
        s = 8'h00;
        for (int i = 0; i < PAY && i < tx_q.size(); i++) s = 8'(s + tx_q[i]);
        ok = (tx_q.size() == PAY + (CS_EN ? 1 : 0));
        if (ok && CS_EN) ok = (tx_q[PAY] == s);
        if (m_pending) begin
            m_overrun = 1'b1;
        end else if (ok) begin
            for (int k = 0; k < int'(NPIX); k++)
                m_back[k] = {tx_q[3*k], tx_q[3*k+1], tx_q[3*k+2]};
            m_pending = 1'b1;
        end else begin
            e = 1'b1;
        end
    endtask

    task automatic model_sync();
        if (m_pending) begin
            m_front   = m_back;
            m_pending = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{12, 8'h01, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 24'h010203, 24'h0A0B0C};
        vecs[1] = '{ 7, 8'h40, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 24'h010203, 24'h0A0B0C};
        vecs[2] = '{12, 8'h20, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 24'h010203, 24'h0A0B0C};
        vecs[3] = '{12, 8'h60, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 24'h202122, 24'h292A2B};
        vecs[4] = '{12, 8'h80, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 24'h808182, 24'h898A8B};
        vecs[5] = '{12, 8'h90, 1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 24'h808182, 24'h898A8B};
        vecs[6] = '{ 0, 8'h00, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 24'h808182, 24'h898A8B};

        reset_n        = 1'b0;
        bus.spi_sclk   = 1'b0;
        bus.spi_mosi   = 1'b0;
        bus.spi_cs_n   = 1'b1;
        bus.frame_sync = 1'b0;
        bus.rd_addr    = '0;
        m_pending      = 1'b0;
        m_overrun      = 1'b0;
        repeat (3) @(negedge clk);
        d = bus.rd_data;
        check("rst_rd_data", 32'(d), 32'h0);
        check("rst_swap_pending", 32'(bus.swap_pending), 32'h0);
        check("rst_overrun_err", 32'(bus.overrun_err), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Scripted frames with hand-derived expectations.
        for (int r = 0; r < 7; r++) begin
            e0 = err_cnt;
            build(vecs[r].npay, vecs[r].base, vecs[r].extra, 1'b0);
            send_frame();
            model_frame(exp_err);
            check($sformatf("vec%0d_frame_err", r), 32'(err_cnt - e0), 32'(vecs[r].exp_err));
            check($sformatf("vec%0d_pend_pre", r), 32'(bus.swap_pending), 32'(vecs[r].exp_pend_pre));
            if (vecs[r].do_sync) begin
                pulse_sync();
                model_sync();
            end
            check($sformatf("vec%0d_pend_post", r), 32'(bus.swap_pending), 32'(vecs[r].exp_pend_post));
            check($sformatf("vec%0d_overrun", r), 32'(bus.overrun_err), 32'(vecs[r].exp_ovr));
            read_px(2'd0, d);
            check($sformatf("vec%0d_px0", r), 32'(d), 32'(vecs[r].exp_px0));
            read_px(2'd3, d);
            check($sformatf("vec%0d_px3", r), 32'(d), 32'(vecs[r].exp_px3));
        end

        // frame_sync high on the edge where swap_pending rises: swap deferred.
        build(PAY, 8'hB0, 0, 1'b0);
        bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        repeat (6) @(negedge clk);
        bus.spi_cs_n   = 1'b1;
        bus.frame_sync = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.swap_pending) seen = 1'b1;
        end
        bus.frame_sync = 1'b0;
        check("same_edge_pend_rise", 32'(seen), 32'h1);
        model_frame(exp_err);
        repeat (3) @(negedge clk);
        check("same_edge_pend_held", 32'(bus.swap_pending), 32'h1);
        read_px(2'd0, d);
        check("same_edge_front_kept", 32'(d), 32'(m_front[0]));
        pulse_sync();
        model_sync();
        check("same_edge_next_swap", 32'(bus.swap_pending), 32'h0);
        read_px(2'd0, d);
        check("same_edge_new_front", 32'(d), 32'h00B0B1B2);

        // Reset after 5 bytes of a frame, cs_n still low through release.
        build(PAY, 8'hD0, 0, 1'b0);
        bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(tx_q[i]);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        d = bus.rd_data;
        check("midrst_rd_data", 32'(d), 32'h0);
        check("midrst_swap_pending", 32'(bus.swap_pending), 32'h0);
        check("midrst_overrun_err", 32'(bus.overrun_err), 32'h0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
        m_pending = 1'b0;
        m_overrun = 1'b0;
        reset_n = 1'b1;
        e0 = err_cnt;
        repeat (4) @(negedge clk);
        send_byte(8'h55);
        send_byte(8'h66);
        repeat (6) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_stale_cs_err", 32'(err_cnt - e0), 32'h0);
        check("midrst_stale_cs_pend", 32'(bus.swap_pending), 32'h0);
        build(PAY, 8'hC0, 0, 1'b0);
        send_frame();
        model_frame(exp_err);
        check("midrst_new_pend", 32'(bus.swap_pending), 32'h1);
        pulse_sync();
        model_sync();
        for (int k = 0; k < int'(NPIX); k++) begin
            read_px(AW'(k), d);
            check($sformatf("midrst_px%0d", k), 32'(d), 32'(24'hC0C1C2 + 24'h030303 * 24'(k)));
        end

`ifdef FRAME_LOADER_CHECKSUM_EN
        // Checksum 0x4E accepted, 0x4F rejected.
        tx_q.delete();
        for (int i = 1; i <= 12; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'h4E);
        e0 = err_cnt;
        send_frame();
        model_frame(exp_err);
        check("csum_good_err", 32'(err_cnt - e0), 32'h0);
        check("csum_good_pend", 32'(bus.swap_pending), 32'h1);
        pulse_sync();
        model_sync();
        read_px(2'd0, d);
        check("csum_good_px0", 32'(d), 32'h010203);
        tx_q[12] = 8'h4F;
        e0 = err_cnt;
        send_frame();
        model_frame(exp_err);
        check("csum_bad_err", 32'(err_cnt - e0), 32'h1);
        check("csum_bad_pend", 32'(bus.swap_pending), 32'h0);
`endif

        // Random frames against the frame-level model.
        for (int it = 0; it < 14; it++) begin
            kind = int'($urandom_range(0, 9));
            base = 8'($urandom);
            if (kind < 6)       build(PAY, base, 0, 1'b0);
            else if (kind < 8)  build(int'($urandom_range(0, PAY - 1)), base, 0, 1'b0);
            else if (kind == 8) build(PAY, base, int'($urandom_range(1, 2)), 1'b0);
            else                build(PAY, base, 0, CS_EN);
            e0 = err_cnt;
            send_frame();
            model_frame(exp_err);
            check($sformatf("rnd%0d_frame_err", it), 32'(err_cnt - e0), 32'(exp_err));
            check($sformatf("rnd%0d_pend", it), 32'(bus.swap_pending), 32'(m_pending));
            check($sformatf("rnd%0d_overrun", it), 32'(bus.overrun_err), 32'(m_overrun));
            if ($urandom_range(0, 1) == 1) begin
                pulse_sync();
                model_sync();
                check($sformatf("rnd%0d_pend_sync", it), 32'(bus.swap_pending), 32'(m_pending));
            end
            a = AW'($urandom_range(0, NPIX - 1));
            read_px(a, d);
            check($sformatf("rnd%0d_px%0d", it, a), 32'(d), 32'(m_front[a]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
